// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bundle between the load/store stage (master) and the
//   data-memory responder (slave).
//
//   Request channel  : req_valid, req_ready, req_wen, req_addr, req_wdata,
//                      req_wstrb (valid/ready handshake, master -> slave)
//   Response channel : rsp_valid, rsp_ready, rsp_rdata, rsp_err
//                      (valid/ready handshake, slave -> master)
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [7:0]      req_wstrb;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    // Requester side (load/store stage).
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder side (memory).
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Synthesizable data-memory responder. Accepts one word-granular read or
//   byte-strobed write per request handshake, keeps the data in a DEPTH x 64-bit
//   array and answers after LATENCY cycles. Only one transaction is in flight;
//   a new request may be accepted in the same cycle the previous response is
//   consumed.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset (array contents are kept)
//   bus  - dmem_responder_if.slave
//            req_valid/req_ready  request handshake (req_ready combinational)
//            req_wen              1 = write, 0 = read
//            req_addr             byte address, bits [2:0] ignored
//            req_wdata/req_wstrb  lane-positioned write data and byte enables
//            rsp_valid/rsp_ready  response handshake
//            rsp_rdata            read word, 0 for writes and errors
//            rsp_err              address outside [BASE, BASE+DEPTH*8)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned     XLEN    = 64,
    parameter int unsigned     DEPTH   = 256,
    parameter logic [XLEN-1:0] BASE    = 64'h0000_0000_8000_0000,
    parameter int unsigned     LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned     IDX_W  = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN   = XLEN'(DEPTH * 32'd8);
    localparam logic [3:0]      LAT_M1 = 4'(LATENCY - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Replace the strobed byte lanes of old_word with those of new_word.
    function automatic logic [XLEN-1:0] merge_bytes(
        input logic [XLEN-1:0] old_word,
        input logic [XLEN-1:0] new_word,
        input logic [7:0]      strb
    );
        logic [XLEN-1:0] res;
        res = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // FSM and latency counter
    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;

    // Request captured at accept, consumed at the commit edge
    logic             wen_r;
    logic [XLEN-1:0]  wdata_r;
    logic [7:0]       wstrb_r;
    logic [IDX_W-1:0] idx_r;
    logic             err_r;

    // Decode of the live request
    logic [XLEN-1:0]  req_off_s;
    logic [IDX_W-1:0] req_idx_s;
    logic             req_err_s;

    // Handshakes
    logic req_ready_s;
    logic accept_s;
    logic rsp_hs_s;

    // Operands used at the commit edge
    logic             commit_s;
    logic             op_wen_s;
    logic [XLEN-1:0]  op_wdata_s;
    logic [7:0]       op_wstrb_s;
    logic [IDX_W-1:0] op_idx_s;
    logic             op_err_s;

    // Registered response
    logic            rsp_valid_r;
    logic [XLEN-1:0] rsp_rdata_r;
    logic            rsp_err_r;

    // Storage (not reset)
    logic [XLEN-1:0] mem_r [DEPTH];

    // Unsigned offset from BASE: addresses below BASE wrap to large values and
    // therefore land in the error range as well.
    assign req_off_s = bus.req_addr - BASE;
    assign req_idx_s = req_off_s[IDX_W+2:3];
    assign req_err_s = (req_off_s >= SPAN);

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign req_ready_s = ~rst & ((state_r == ST_IDLE) |
                                 ((state_r == ST_RESP) & bus.rsp_ready));
    assign accept_s    = bus.req_valid & req_ready_s;
    assign rsp_hs_s    = rsp_valid_r & bus.rsp_ready;

    // Next-state, counter reload and commit decision
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 32'd1) begin
                        state_nxt_s = ST_RESP;
                        commit_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = LAT_M1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_RESP;
                    cnt_nxt_s   = 4'd0;
                    commit_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    if (accept_s) begin
                        if (LATENCY == 32'd1) begin
                            state_nxt_s = ST_RESP;
                            commit_s    = 1'b1;
                        end else begin
                            state_nxt_s = ST_WAIT;
                            cnt_nxt_s   = LAT_M1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Commit operands: from WAIT the captured request is used; with a
    // single-cycle latency the commit coincides with the accept, so the live
    // request is used directly.
    always_comb begin
        if (state_r == ST_WAIT) begin
            op_wen_s   = wen_r;
            op_wdata_s = wdata_r;
            op_wstrb_s = wstrb_r;
            op_idx_s   = idx_r;
            op_err_s   = err_r;
        end else begin
            op_wen_s   = bus.req_wen;
            op_wdata_s = bus.req_wdata;
            op_wstrb_s = bus.req_wstrb;
            op_idx_s   = req_idx_s;
            op_err_s   = req_err_s;
        end
    end

    // State register and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Capture the request at the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_r   <= 1'b0;
            wdata_r <= {XLEN{1'b0}};
            wstrb_r <= 8'd0;
            idx_r   <= {IDX_W{1'b0}};
            err_r   <= 1'b0;
        end else if (accept_s) begin
            wen_r   <= bus.req_wen;
            wdata_r <= bus.req_wdata;
            wstrb_r <= bus.req_wstrb;
            idx_r   <= req_idx_s;
            err_r   <= req_err_s;
        end
    end

    // Response registers: loaded at commit, held through backpressure,
    // cleared after the handshake when no new response follows immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (commit_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= op_err_s;
            rsp_rdata_r <= (op_err_s | op_wen_s) ? {XLEN{1'b0}} : mem_r[op_idx_s];
        end else if (rsp_hs_s) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
        end
    end

    // Array write at the commit edge; commit_s is never set during reset, so a
    // captured write interrupted by reset never reaches the array.
    always_ff @(posedge clk) begin
        if (commit_s && op_wen_s && !op_err_s) begin
            mem_r[op_idx_s] <= merge_bytes(mem_r[op_idx_s], op_wdata_s, op_wstrb_s);
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A reference memory model computes
//   the expected response when each request is driven; expectations are queued
//   and popped when the responder presents rsp_valid.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          LAT   = 2;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    logic [63:0] ref_mem [DEPTH];

    dmem_responder_if #(.XLEN(XLEN)) bus ();

    dmem_responder #(
        .XLEN(XLEN), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic m_err(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE;
        return (off >= 64'(DEPTH * 8));
    endfunction

    function automatic int m_idx(input logic [63:0] addr);
        logic [63:0] off;
        off = (addr - BASE) >> 3;
        return int'(off % 64'(DEPTH));
    endfunction

    // Compute expected response, update the reference memory, queue it.
    task automatic model_issue(input logic wen, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] strb);
        exp_t e;
        int   idx;
        if (m_err(addr)) begin
            e.rdata = 64'd0;
            e.err   = 1'b1;
        end else begin
            idx   = m_idx(addr);
            e.err = 1'b0;
            if (wen) begin
                e.rdata = 64'd0;
                for (int b = 0; b < 8; b++) begin
                    if (strb[b]) ref_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end else begin
                e.rdata = ref_mem[idx];
            end
        end
        exp_q.push_back(e);
    endtask

    // Drive a request and wait (bounded) for the accept edge; returns at +1.
    task automatic drive_and_accept(input string name, input logic wen,
                                    input logic [63:0] addr, input logic [63:0] wdata,
                                    input logic [7:0] strb);
        bit got;
        got = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) got = 1'b1;
            @(posedge clk); #1;
            if (got) break;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_accept: req_ready never high, got=%0d expected=1", name, got);
        end
    endtask

    // One full transaction with rsp_ready held high.
    task automatic do_txn(input string name, input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] strb,
                          output logic [63:0] rdata_o);
        int   lat;
        exp_t e;
        bus.rsp_ready = 1'b1;
        model_issue(wen, addr, wdata, strb);
        drive_and_accept(name, wen, addr, wdata, strb);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== LAT) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
        end
        rdata_o = bus.rsp_rdata;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rsp_rdata !== e.rdata) begin
                failures++;
                $display("FAIL %s_rdata: got %h expected %h", name, bus.rsp_rdata, e.rdata);
            end
            checks++;
            if (bus.rsp_err !== e.err) begin
                failures++;
                $display("FAIL %s_err: got %b expected %b", name, bus.rsp_err, e.err);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: rsp_valid got %b expected 0", name, bus.rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 64'd0;
        bus.req_wdata = 64'd0;
        bus.req_wstrb = 8'd0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 64'd0 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h e=%b expected 0/0/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        checks++;
        if (bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_in_reset: got %b expected 0", bus.req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after: got %b expected 1", bus.req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [63:0] d;
        do_txn("wr_full", 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, d);
        do_txn("rd_unaligned", 1'b0, 64'h8000_0013, 64'd0, 8'h00, d);
        checks++;
        if (d !== 64'h1122_3344_5566_7788) begin
            failures++;
            $display("FAIL rd_unaligned_const: got %h expected 1122334455667788", d);
        end
    endtask

    task automatic test_byte_write();
        logic [63:0] d;
        do_txn("wr_byte", 1'b1, 64'h8000_0010, 64'h0000_0000_00AB_0000, 8'h04, d);
        do_txn("rd_byte", 1'b0, 64'h8000_0010, 64'd0, 8'h00, d);
        checks++;
        if (d !== 64'h1122_3344_55AB_7788) begin
            failures++;
            $display("FAIL rd_byte_const: got %h expected 1122334455ab7788", d);
        end
        do_txn("wr_nostrb", 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, d);
        do_txn("rd_nostrb", 1'b0, 64'h8000_0010, 64'd0, 8'h00, d);
        checks++;
        if (d !== 64'h1122_3344_55AB_7788) begin
            failures++;
            $display("FAIL rd_nostrb_const: got %h expected 1122334455ab7788", d);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        logic [63:0] hold;
        int          w;
        exp_t        e;
        do_txn("bp_setup", 1'b1, 64'h8000_0030, 64'h0606_0606_0606_0606, 8'hFF, d);
        bus.rsp_ready = 1'b0;
        model_issue(1'b0, 64'h8000_0030, 64'd0, 8'h00);
        drive_and_accept("bp_rd", 1'b0, 64'h8000_0030, 64'd0, 8'h00);
        w = 0;
        while (!bus.rsp_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        hold = bus.rsp_rdata;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== hold) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d got v=%b d=%h expected v=1 d=%h",
                         c, bus.rsp_valid, bus.rsp_rdata, hold);
            end
            checks++;
            if (bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready: cycle %0d got %b expected 0", c, bus.req_ready);
            end
            if (c == 1) begin
                bus.req_valid = 1'b1;
                bus.req_wen   = 1'b1;
                bus.req_addr  = 64'h8000_0030;
                bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
                bus.req_wstrb = 8'hFF;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            failures++;
            $display("FAIL bp_rdata: got %h/%b expected %h/%b",
                     bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: rsp_valid got %b expected 0", bus.rsp_valid);
        end
        do_txn("bp_recheck", 1'b0, 64'h8000_0030, 64'd0, 8'h00, d);
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        logic [63:0] a [4];
        int   sent, seen, cyc, first_acc;
        bit   acc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            a[i] = BASE + 64'((8 + i) * 8);
            do_txn("b2b_setup", 1'b1, a[i], {8{8'(8'h40 + i)}}, 8'hFF, d);
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) model_issue(1'b0, a[i], 64'd0, 8'h00);
        sent = 0; seen = 0; cyc = 0; first_acc = 0;
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = a[0];
        while (seen < 4 && cyc < 40) begin
            acc = bus.req_valid && bus.req_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent == 0) first_acc = cyc;
                sent++;
                if (sent < 4) bus.req_addr = a[sent];
                else bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid) begin
                checks++;
                if (cyc + 1 !== first_acc + LAT * (seen + 1)) begin
                    failures++;
                    $display("FAIL b2b_timing: rsp %0d at edge %0d expected %0d",
                             seen, cyc + 1 - first_acc, LAT * (seen + 1));
                end
                checks++;
                if (bus.req_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready: rsp %0d got %b expected 1", seen, bus.req_ready);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                        failures++;
                        $display("FAIL b2b_rdata: rsp %0d got %h/%b expected %h/%b",
                                 seen, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                    end
                end
                seen++;
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        if (seen !== 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d responses expected 4", seen);
        end
        @(posedge clk); #1;
        exp_q.delete();
    endtask

    task automatic test_errors();
        logic [63:0] d;
        do_txn("err_setup", 1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, d);
        do_txn("err_below", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, d);
        checks++;
        if (d !== 64'd0) begin
            failures++;
            $display("FAIL err_below_const: got %h expected 0", d);
        end
        do_txn("err_above", 1'b1, 64'h8000_0800, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, d);
        do_txn("err_noalias", 1'b0, 64'h8000_0000, 64'd0, 8'h00, d);
        checks++;
        if (d !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL err_noalias_const: got %h expected 0123456789abcdef", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        int          w;
        do_txn("rm_setup", 1'b1, 64'h8000_0020, 64'h0000_0000_0000_005A, 8'hFF, d);
        // Write accepted, then reset before its commit edge.
        bus.rsp_ready = 1'b1;
        drive_and_accept("rm_wr", 1'b1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_valid: got %b expected 0", bus.rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_txn("rm_read", 1'b0, 64'h8000_0020, 64'd0, 8'h00, d);
        checks++;
        if (d !== 64'h0000_0000_0000_005A) begin
            failures++;
            $display("FAIL rm_read_const: got %h expected 5a", d);
        end
        // Pending response lost asynchronously.
        bus.rsp_ready = 1'b0;
        drive_and_accept("rm_rd", 1'b0, 64'h8000_0020, 64'd0, 8'h00);
        w = 0;
        while (!bus.rsp_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_pending: got %b expected 1", bus.rsp_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_async_drop: got %b expected 0", bus.rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_ready: got %b expected 1", bus.req_ready);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_backpressure();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
